// File: rtl/pe_rr_arbiter.sv
// Purpose : round-robin share of one NoC injection port among NUM_REQ PE streams.
// Latency : 1 cycle from the requester handshake to o_valid.
// Backpr. : full throughput; when holding a packet and i_ready=0, all o_ready=0 and the pointer freezes.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_data       NUM_REQ packed packets, requester k at [k*total_width +: total_width]
//   i_valid      per-requester valid
//   o_ready      per-requester ready, at most one bit high
//   o_data       packet {payload | pck_num | y | x} to the router, LSB first
//   o_valid      output register holds a packet
//   i_ready      router ready
//   o_grant      one-hot source of the held packet, 0 when empty
//   o_pkt_count  per-requester 16-bit accepted-packet counters
//                (present only when PE_RR_ARBITER_PKT_COUNT_EN is defined)
module pe_rr_arbiter #(
    parameter int total_width = 32,
    parameter int x_size      = 4,
    parameter int y_size      = 4,
    parameter int pck_num     = 8,
    parameter int NUM_REQ     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*total_width-1:0] i_data,
    input  logic [NUM_REQ-1:0]             i_valid,
    output logic [NUM_REQ-1:0]             o_ready,
    output logic [total_width-1:0]         o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [NUM_REQ-1:0]             o_grant
`ifdef PE_RR_ARBITER_PKT_COUNT_EN
    ,
    output logic [NUM_REQ*16-1:0]          o_pkt_count
`endif
);

    localparam int PTR_W     = $clog2(NUM_REQ);
    localparam int PAYLOAD_W = total_width - pck_num - y_size - x_size;

    // Single-flit packet layout; carried through untouched.
    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [pck_num-1:0]   num;
        logic [y_size-1:0]    y;
        logic [x_size-1:0]    x;
    } pkt_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    pkt_t                 pkt_q, pkt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     last_q, last_d;
    logic [PTR_W-1:0]     sel;
    logic                 any_vld;
    logic                 can_load;
    logic                 xfer;

    // Search starts just past the last granted requester and wraps, so the
    // most recently served requester has lowest priority.
    always_comb begin
        sel     = last_q;
        any_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_vld && i_valid[PTR_W'((int'(last_q) + i) % NUM_REQ)]) begin
                sel     = PTR_W'((int'(last_q) + i) % NUM_REQ);
                any_vld = 1'b1;
            end
        end
    end

    // A drain and a load may share a cycle, so a full register can still load.
    assign can_load = (state_q == EMPTY) | i_ready;
    // Reset gates the handshake so nothing is accepted in the reset cycle.
    assign xfer     = any_vld & can_load & ~rst;

    always_comb begin
        o_ready = '0;
        if (xfer) begin
            o_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (xfer) begin
            state_d      = FULL;
            pkt_d        = pkt_t'(i_data[int'(sel)*total_width +: total_width]);
            grant_d      = '0;
            grant_d[sel] = 1'b1;
            last_d       = sel;
        end else if (state_q == FULL && i_ready) begin
            // Drained with nothing to reload; o_data keeps its last value.
            state_d = EMPTY;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            pkt_q   <= '0;
            grant_q <= '0;
            last_q  <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign o_valid = (state_q == FULL);
    assign o_data  = pkt_q;
    assign o_grant = grant_q;

`ifdef PE_RR_ARBITER_PKT_COUNT_EN
    logic [15:0] pkt_cnt_q [NUM_REQ];

    // Free-running counters; wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                pkt_cnt_q[k] <= '0;
            end
        end else if (xfer) begin
            pkt_cnt_q[sel] <= pkt_cnt_q[sel] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign o_pkt_count[g*16 +: 16] = pkt_cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_pe_rr_arbiter.sv
// Purpose : self-checking bench for pe_rr_arbiter against a cycle-level reference model.
// Latency : checks every cycle at the falling edge, model advances once per rising edge.
// Backpr. : stimulus drives i_ready randomly and in directed hold/toggle patterns.
module tb_pe_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   i_data;
    logic [N-1:0]     i_valid;
    logic [N-1:0]     o_ready;
    logic [W-1:0]     o_data;
    logic             o_valid;
    logic             i_ready;
    logic [N-1:0]     o_grant;
`ifdef PE_RR_ARBITER_PKT_COUNT_EN
    logic [N*16-1:0]  o_pkt_count;
`endif

    always #5 clk = ~clk;

    pe_rr_arbiter #(
        .total_width (W),
        .x_size      (4),
        .y_size      (4),
        .pck_num     (8),
        .NUM_REQ     (N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_grant     (o_grant)
`ifdef PE_RR_ARBITER_PKT_COUNT_EN
        ,
        .o_pkt_count (o_pkt_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: output register contents, last grant, counters.
    bit             m_valid;
    logic [W-1:0]   m_data;
    logic [N-1:0]   m_grant;
    int             m_last;
    int             m_cnt [N];
    logic [W-1:0]   sb_q [$];
    logic [N-1:0]   deliv_grant [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Round-robin rule: first valid requester after the last one served.
    function automatic int model_sel();
        for (int i = 1; i <= N; i++) begin
            if (i_valid[(m_last + i) % N]) return (m_last + i) % N;
        end
        return -1;
    endfunction

    // Called just after a rising edge with inputs already driven.
    task automatic cycle();
        int          k;
        bit          can_load;
        bit          xfer;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        k        = model_sel();
        can_load = !m_valid || i_ready;
        xfer     = !rst && can_load && (k >= 0);
        exp_rdy  = '0;
        if (xfer) exp_rdy[k] = 1'b1;
        check("o_valid", 64'(o_valid), 64'(m_valid));
        check("o_data",  64'(o_data),  64'(m_data));
        check("o_grant", 64'(o_grant), 64'(m_grant));
        check("o_ready", 64'(o_ready), 64'(exp_rdy));
`ifdef PE_RR_ARBITER_PKT_COUNT_EN
        for (int j = 0; j < N; j++) begin
            check("pkt_cnt", 64'(o_pkt_count[j*16 +: 16]), 64'(m_cnt[j]));
        end
`endif
        // Scoreboard: every delivered beat must be the oldest accepted one.
        if (!rst && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_beat", 64'(1), 64'(0));
            end else begin
                check("sb_data", 64'(o_data), 64'(sb_q.pop_front()));
            end
            deliv_grant.push_back(o_grant);
        end
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_grant = '0;
            m_last  = N - 1;
            sb_q.delete();
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
        end else if (xfer) begin
            m_data   = i_data[k*W +: W];
            m_grant  = '0;
            m_grant[k] = 1'b1;
            m_valid  = 1'b1;
            m_last   = k;
            m_cnt[k] = (m_cnt[k] + 1) & 16'hFFFF;
            sb_q.push_back(m_data);
        end else if (m_valid && i_ready) begin
            m_valid = 1'b0;
            m_grant = '0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] rr_exp [N];

    initial begin
        rr_exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        m_valid = 1'b0; m_data = '0; m_grant = '0; m_last = N - 1;
        for (int j = 0; j < N; j++) m_cnt[j] = 0;

        rst = 1'b1; i_valid = '0; i_ready = 1'b0; i_data = '0;
        @(posedge clk); #1;
        cycle();
        // Ready must stay low during reset even with every requester valid.
        i_valid = '1; i_ready = 1'b1;
        cycle();
        rst = 1'b0;

        // All requesters valid: strict rotation with no gaps.
        for (int j = 0; j < N; j++) i_data[j*W +: W] = rr_exp[j];
        cycle();
        for (int j = 0; j < 8; j++) begin
            check("rr_seq_data",  64'(o_data),  64'(rr_exp[j % N]));
            check("rr_seq_valid", 64'(o_valid), 64'(1));
            cycle();
        end

        // Single active requester is granted every cycle.
        i_valid = 4'b0100;
        i_data[2*W +: W] = 32'hA5A5_0302;
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("single_grant", 64'(o_grant), 64'(4'b0100));
            check("single_data",  64'(o_data),  64'(32'hA5A5_0302));
        end

        // Hold under back-pressure, then resume with the pointer where it was.
        i_valid = 4'b0010;
        i_data[1*W +: W] = 32'h0B0B_0101;
        cycle();
        i_valid = 4'b1001; i_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle();
            check("hold_grant", 64'(o_grant), 64'(4'b0010));
            check("hold_data",  64'(o_data),  64'(32'h0B0B_0101));
        end
        i_ready = 1'b1;
        cycle();
        check("resume_first",  64'(o_grant), 64'(4'b1000));
        cycle();
        check("resume_second", 64'(o_grant), 64'(4'b0001));

        // Toggling router ready: each beat delivered once, alternating sources.
        rst = 1'b1; i_valid = '0;
        cycle();
        rst = 1'b0;
        deliv_grant.delete();
        i_valid = 4'b0011;
        for (int j = 0; j < 8; j++) begin
            i_ready = (j % 2 == 0);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        i_valid = '0; i_ready = 1'b1;
        cycle();
        cycle();
        check("toggle_count", 64'(deliv_grant.size()), 64'(4));
        for (int j = 0; j < deliv_grant.size() && j < 4; j++) begin
            check("toggle_order", 64'(deliv_grant[j]), 64'(4'b0001 << (j % 2)));
        end

        // Reset while full discards the packet and restores priority to 0.
        i_valid = 4'b0100; i_ready = 1'b0;
        i_data[2*W +: W] = 32'hDEAD_0001;
        cycle();
        check("pre_rst_data", 64'(o_data), 64'(32'hDEAD_0001));
        rst = 1'b1; i_valid = '1;
        cycle();
        rst = 1'b0;
        check("post_rst_valid", 64'(o_valid), 64'(0));
        check("post_rst_grant", 64'(o_grant), 64'(0));
        i_ready = 1'b1;
        cycle();
        check("post_rst_first", 64'(o_grant), 64'(4'b0001));

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 400; j++) begin
            i_valid = N'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            i_data  = {$urandom, $urandom, $urandom, $urandom};
            rst     = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst = 1'b0;

`ifdef PE_RR_ARBITER_PKT_COUNT_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        i_valid = 4'b0001; i_ready = 1'b1;
        for (int j = 0; j < 65537; j++) cycle();
        check("cnt_wrap_r0", 64'(o_pkt_count[15:0]),  64'(1));
        check("cnt_wrap_r1", 64'(o_pkt_count[31:16]), 64'(0));
        check("cnt_wrap_r2", 64'(o_pkt_count[47:32]), 64'(0));
        check("cnt_wrap_r3", 64'(o_pkt_count[63:48]), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_rr_arbiter.md
Name: pe_rr_arbiter

Overview:
- Round-robin scheduler that shares one NoC injection port between NUM_REQ processing-element output streams (e.g. inverter PEs).
- Each beat is one complete single-flit packet: {payload | pck_num | y | x}, LSB first.
- Accepts at most one packet per cycle from the selected requester and holds it in a one-entry output register.
- Forwards it unmodified to the router-facing valid/ready port.

Parameters:
- total_width, 32, packet width in bits
- x_size, 4, width of x-address field [x_size-1:0]
- y_size, 4, width of y-address field above x
- pck_num, 8, width of packet-number field above y
- NUM_REQ, 4, number of requesters (2..16)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_data  input  NUM_REQ*total_width  requester packets; requester k occupies bits [k*total_width +: total_width]
- i_valid  input  NUM_REQ  per-requester valid
- o_ready  output  NUM_REQ  per-requester ready; at most one bit high per cycle
- o_data  output  total_width  packet to router
- o_valid  output  1  output register holds a packet
- i_ready  input  1  router ready
- o_grant  output  NUM_REQ  one-hot index of the requester whose packet is in the output register; 0 when empty

Behaviour:
- Reset values (registered outputs): o_valid=0, o_data=0, o_grant=0.
- Reset values (internal): last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- o_ready is combinational from state; it is 0 during the reset cycle.
- Output register states:
  - EMPTY (o_valid=0)
  - FULL (o_valid=1)
- can_load = ~o_valid | i_ready. Full throughput: a drain and a load in the same cycle are allowed.
- Selection:
  - Combinational search of i_valid starting at (last+1) mod NUM_REQ and wrapping.
  - The first asserted index is sel.
  - o_ready[sel] = can_load & |i_valid; all other o_ready bits are 0.
- Transfer from requester k occurs when i_valid[k] & o_ready[k]. On transfer:
  - o_data <= i_data slice k
  - o_grant <= one-hot(k)
  - o_valid <= 1
  - last <= k
- Output handshake:
  - When o_valid & i_ready and no load occurs: o_valid <= 0 and o_grant <= 0.
  - o_data keeps its last value.
- Stability: while o_valid & ~i_ready, o_data, o_valid and o_grant hold constant (AXI-stream rule).
- Latency: 1 cycle from the accepting handshake to o_valid.
- Fairness: with all NUM_REQ requesters continuously valid and i_ready=1, grants cycle 0,1,..,NUM_REQ-1,0,… with no gaps. Any continuously valid requester waits at most NUM_REQ-1 transfers.
- Pointer rules:
  - With a single active requester, it is granted every cycle.
  - The pointer advances only on transfer, never on idle cycles.
- Back-pressure: when FULL and i_ready=0, all o_ready=0 and the pointer is frozen.
- A requester dropping i_valid before being granted is legal. Nothing is latched for it; selection re-evaluates each cycle.
- Reset mid-operation: a held packet is discarded and the pointer returns to NUM_REQ-1. No packet is transferred in the reset cycle.
- No packet fields are modified. Address fields are passed through bit-exact.

Optional Feature:
- Macro: PE_RR_ARBITER_PKT_COUNT_EN
- Defined:
  - Adds output port o_pkt_count [NUM_REQ*16-1:0].
  - Holds one 16-bit counter per requester, each incremented on that requester's accepted transfer.
  - Counters wrap 16'hFFFF→0 and are cleared by rst.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- After rst, all i_valid=1, i_ready=1, NUM_REQ=4, i_data slices 32'h11,32'h22,32'h33,32'h44 → o_data sequence 11,22,33,44,11… from the cycle after the first accept; o_valid is continuous.
- Only requester 2 valid with data 32'hA5A5_0302, i_ready=1 → o_ready=4'b0100 every cycle; o_data=A5A50302, o_grant=4'b0100 each cycle.
- Load packet from requester 1, then hold i_ready=0 for 5 cycles with requesters 0 and 3 valid → o_data/o_grant stable, o_ready=0. On i_ready=1, the next grant is requester 3, then 0.
- Requesters 0 and 1 valid, i_ready toggling 1,0,1,0 → every beat is delivered exactly once in order 0,1,0,1; no duplicates or drops (scoreboard).
- Assert rst while FULL with o_data=32'hDEAD_0001 → next cycle o_valid=0, o_grant=0; the first post-reset grant with all requesters valid goes to requester 0.
- With PE_RR_ARBITER_PKT_COUNT_EN, drive 65537 beats from requester 0 → its counter reads 1 and the other counters read 0.
